pipe_ctrl_gen: RTL and testbench

//  Parametrised pipeline stall/flush controller; successor to the fixed 6-stage controller.

---
 rtl/pipe_ctrl_gen_pkg.sv | 26 ++
 rtl/pipe_ctrl_gen_stall_prio.sv | 25 ++
 rtl/pipe_ctrl_gen.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Stall map rows are packed with row 0 (highest priority) in the least significant slice.
package pipe_ctrl_gen_pkg;

    localparam int STALLBUS_WD = 6;
    localparam int NUM_REQ_DFLT = 6;

    typedef enum logic [1:0] {
        PCG_IDLE  = 2'd0,
        PCG_DRAIN = 2'd1,
        PCG_FLUSH = 2'd2
    } pcg_state_e;

    localparam logic [STALLBUS_WD-1:0] STALL_ROW_EX   = 6'b111101;
    localparam logic [STALLBUS_WD-1:0] STALL_ROW_BRU  = 6'b001101;
    localparam logic [STALLBUS_WD-1:0] STALL_ROW_LOAD = 6'b000101;
    localparam logic [STALLBUS_WD-1:0] STALL_ROW_MDU  = 6'b011101;
    localparam logic [STALLBUS_WD-1:0] STALL_ROW_IC   = 6'b000001;
    localparam logic [STALLBUS_WD-1:0] STALL_ROW_DC   = 6'b111111;

    localparam logic [NUM_REQ_DFLT*STALLBUS_WD-1:0] STALL_MAP_DFLT = {
        STALL_ROW_DC, STALL_ROW_IC, STALL_ROW_MDU,
        STALL_ROW_LOAD, STALL_ROW_BRU, STALL_ROW_EX
    };

endpackage

// File: rtl/pipe_ctrl_gen_stall_prio.sv
// pcg_stall_prio: picks the STALL_MAP row of the lowest-index active stall request.
module pcg_stall_prio
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int NUM_STAGES = STALLBUS_WD,
    parameter int NUM_REQ    = NUM_REQ_DFLT,
    parameter logic [NUM_REQ*NUM_STAGES-1:0] STALL_MAP = STALL_MAP_DFLT
) (
    input  logic [NUM_REQ-1:0]    stall_req,
    output logic [NUM_STAGES-1:0] stall_vec
);

    // Scan from lowest priority upward so the lowest active index is written last.
    always_comb begin
        stall_vec = {NUM_STAGES{1'b0}};
        for (int r = NUM_REQ - 1; r >= 0; r--) begin
            if (stall_req[r]) begin
                stall_vec = STALL_MAP[r*NUM_STAGES +: NUM_STAGES];
            end else begin
                stall_vec = stall_vec;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller: priority stall bus, drain-deferred registered redirect.
// Optional stall watchdog built when PIPE_CTRL_WDOG_EN is defined.
module pipe_ctrl_gen
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int NUM_STAGES = STALLBUS_WD,
    parameter int NUM_REQ    = NUM_REQ_DFLT,
    parameter logic [NUM_REQ*NUM_STAGES-1:0] STALL_MAP = STALL_MAP_DFLT,
    parameter int FLUSH_LEN  = 1,
    parameter int PC_W       = 32,
    parameter int WDOG_LIMIT = 1023
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    stall_req,
    input  logic                  excp_valid,
    input  logic [PC_W-1:0]       excp_pc,
    input  logic                  drain_busy,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [PC_W-1:0]       new_pc,
    output logic                  wdog_timeout
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_LEN - 1);

    pcg_state_e             state_r, state_next_s;
    logic [PC_W-1:0]        pend_pc_r, pend_pc_next_s;
    logic [3:0]             flush_cnt_r, flush_cnt_next_s;
    logic                   flush_r;
    logic [PC_W-1:0]        new_pc_r;
    logic [NUM_STAGES-1:0]  prio_stall_s;
    logic [NUM_STAGES-1:0]  stall_s;

    pcg_stall_prio #(
        .NUM_STAGES (NUM_STAGES),
        .NUM_REQ    (NUM_REQ),
        .STALL_MAP  (STALL_MAP)
    ) u_stall_prio (
        .stall_req  (stall_req),
        .stall_vec  (prio_stall_s)
    );

    // Stall bus: silent during flush, fully frozen while waiting for the bus to drain.
    always_comb begin
        if (flush_r) begin
            stall_s = {NUM_STAGES{1'b0}};
        end else if (state_r == PCG_DRAIN) begin
            stall_s = {NUM_STAGES{1'b1}};
        end else begin
            stall_s = prio_stall_s;
        end
    end

    assign stall  = stall_s;
    assign flush  = flush_r;
    assign new_pc = new_pc_r;

    // Next-state logic; the first captured redirect target wins until the flush completes.
    always_comb begin
        state_next_s     = state_r;
        pend_pc_next_s   = pend_pc_r;
        flush_cnt_next_s = flush_cnt_r;
        case (state_r)
            PCG_IDLE: begin
                if (excp_valid) begin
                    pend_pc_next_s = excp_pc;
                    if (drain_busy) begin
                        state_next_s = PCG_DRAIN;
                    end else begin
                        state_next_s     = PCG_FLUSH;
                        flush_cnt_next_s = FLUSH_LOAD;
                    end
                end else begin
                    state_next_s = PCG_IDLE;
                end
            end
            PCG_DRAIN: begin
                if (!drain_busy) begin
                    state_next_s     = PCG_FLUSH;
                    flush_cnt_next_s = FLUSH_LOAD;
                end else begin
                    state_next_s = PCG_DRAIN;
                end
            end
            PCG_FLUSH: begin
                if (flush_cnt_r == 4'd0) begin
                    state_next_s = PCG_IDLE;
                end else begin
                    flush_cnt_next_s = flush_cnt_r - 4'd1;
                end
            end
            default: begin
                state_next_s     = PCG_IDLE;
                flush_cnt_next_s = 4'd0;
            end
        endcase
    end

    // State, redirect target and registered flush/new_pc outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= PCG_IDLE;
            pend_pc_r   <= {PC_W{1'b0}};
            flush_cnt_r <= 4'd0;
            flush_r     <= 1'b0;
            new_pc_r    <= {PC_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            pend_pc_r   <= pend_pc_next_s;
            flush_cnt_r <= flush_cnt_next_s;
            flush_r     <= (state_next_s == PCG_FLUSH);
            new_pc_r    <= (state_next_s == PCG_FLUSH) ? pend_pc_next_s : {PC_W{1'b0}};
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    logic [9:0] wdog_cnt_r;
    logic       wdog_r;

    // Consecutive-stall counter (saturating) with a sticky timeout flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdog_cnt_r <= 10'd0;
            wdog_r     <= 1'b0;
        end else begin
            if (flush_r || (stall_s == {NUM_STAGES{1'b0}})) begin
                wdog_cnt_r <= 10'd0;
            end else if (wdog_cnt_r != 10'h3FF) begin
                wdog_cnt_r <= wdog_cnt_r + 10'd1;
            end else begin
                wdog_cnt_r <= wdog_cnt_r;
            end
            wdog_r <= wdog_r | (wdog_cnt_r == 10'(WDOG_LIMIT));
        end
    end

    assign wdog_timeout = wdog_r;
`else
    assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed self-checking bench for pipe_ctrl_gen: two instances (flush length 1 and 3).
// Watchdog scenario is exercised when PIPE_CTRL_WDOG_EN is defined.
module tb_pipe_ctrl_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  stall_req;
    logic        excp_valid;
    logic [31:0] excp_pc;
    logic        drain_busy;

    logic [5:0]  stall, stall3;
    logic        flush, flush3;
    logic [31:0] new_pc, new_pc3;
    logic        wdog, wdog3;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    pipe_ctrl_gen #(.FLUSH_LEN(1), .WDOG_LIMIT(8)) dut (
        .clk(clk), .resetn(resetn), .stall_req(stall_req), .excp_valid(excp_valid),
        .excp_pc(excp_pc), .drain_busy(drain_busy), .stall(stall), .flush(flush),
        .new_pc(new_pc), .wdog_timeout(wdog)
    );

    pipe_ctrl_gen #(.FLUSH_LEN(3), .WDOG_LIMIT(8)) dut3 (
        .clk(clk), .resetn(resetn), .stall_req(stall_req), .excp_valid(excp_valid),
        .excp_pc(excp_pc), .drain_busy(drain_busy), .stall(stall3), .flush(flush3),
        .new_pc(new_pc3), .wdog_timeout(wdog3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; stall_req = 6'd0; excp_valid = 1'b0; excp_pc = 32'd0; drain_busy = 1'b0;
        #22;
        vec_cnt++;
        if ({stall, flush, new_pc, wdog} !== {6'd0, 1'b0, 32'd0, 1'b0}) begin
            err_cnt++; $display("FAIL reset: stall=%b flush=%b new_pc=%h wdog=%b, want 0", stall, flush, new_pc, wdog);
        end
        vec_cnt++;
        if ({stall3, flush3, new_pc3, wdog3} !== {6'd0, 1'b0, 32'd0, 1'b0}) begin
            err_cnt++; $display("FAIL reset3: stall=%b flush=%b new_pc=%h", stall3, flush3, new_pc3);
        end
        #2 resetn = 1'b1;
        step();
    endtask

    task automatic test_stall_prio();
        logic [5:0] req_tab [5] = '{6'b000100, 6'b000101, 6'b000010, 6'b110000, 6'b000000};
        logic [5:0] exp_tab [5] = '{6'b000101, 6'b111101, 6'b001101, 6'b000001, 6'b000000};
        for (int i = 0; i < 5; i++) begin
            stall_req = req_tab[i];
            #1;
            vec_cnt++;
            if (stall !== exp_tab[i]) begin
                err_cnt++; $display("FAIL stall_prio[%0d]: req=%b stall=%b want %b", i, req_tab[i], stall, exp_tab[i]);
            end
        end
        step();
    endtask

    task automatic test_excp_basic();
        stall_req = 6'b000100;
        excp_valid = 1'b1; excp_pc = 32'hBFC00380; drain_busy = 1'b0;
        #1;
        vec_cnt++;
        if (flush !== 1'b0) begin
            err_cnt++; $display("FAIL excp_no_comb: flush=%b want 0", flush);
        end
        step();
        excp_valid = 1'b0;
        vec_cnt++;
        if ({flush, new_pc, stall} !== {1'b1, 32'hBFC00380, 6'd0}) begin
            err_cnt++; $display("FAIL excp_flush: flush=%b new_pc=%h stall=%b want 1/bfc00380/0", flush, new_pc, stall);
        end
        step();
        vec_cnt++;
        if ({flush, new_pc, stall} !== {1'b0, 32'd0, 6'b000101}) begin
            err_cnt++; $display("FAIL excp_end: flush=%b new_pc=%h stall=%b want 0/0/000101", flush, new_pc, stall);
        end
        stall_req = 6'd0;
        repeat (4) step();
    endtask

    task automatic test_drain();
        drain_busy = 1'b1; excp_valid = 1'b1; excp_pc = 32'h80000180;
        for (int c = 0; c < 5; c++) begin
            step();
            excp_valid = (c == 1);
            excp_pc = (c == 1) ? 32'h1234_5678 : 32'h80000180;
            vec_cnt++;
            if ({stall, flush} !== {6'b111111, 1'b0}) begin
                err_cnt++; $display("FAIL drain_hold[%0d]: stall=%b flush=%b want 111111/0", c, stall, flush);
            end
        end
        excp_valid = 1'b0; drain_busy = 1'b0;
        step();
        vec_cnt++;
        if ({flush, new_pc, stall} !== {1'b1, 32'h80000180, 6'd0}) begin
            err_cnt++; $display("FAIL drain_flush: flush=%b new_pc=%h stall=%b want 1/80000180/0", flush, new_pc, stall);
        end
        step();
        vec_cnt++;
        if ({flush, new_pc} !== {1'b0, 32'd0}) begin
            err_cnt++; $display("FAIL drain_end: flush=%b new_pc=%h want 0/0", flush, new_pc);
        end
        repeat (4) step();
    endtask

    task automatic test_flush_len();
        logic exp_fl [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_pc;
        excp_valid = 1'b1; excp_pc = 32'hA000_0200;
        for (int c = 0; c < 5; c++) begin
            step();
            excp_valid = (c == 0);
            excp_pc = (c == 0) ? 32'hDEAD_BEEF : 32'hA000_0200;
            exp_pc = exp_fl[c] ? 32'hA000_0200 : 32'd0;
            vec_cnt++;
            if ({flush3, new_pc3} !== {exp_fl[c], exp_pc}) begin
                err_cnt++; $display("FAIL flush_len[%0d]: flush=%b new_pc=%h want %b/%h", c, flush3, new_pc3, exp_fl[c], exp_pc);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_drain();
        drain_busy = 1'b1; excp_valid = 1'b1; excp_pc = 32'hC0DE_0000;
        step();
        excp_valid = 1'b0;
        vec_cnt++;
        if (stall !== 6'b111111) begin
            err_cnt++; $display("FAIL rst_drain_pre: stall=%b want 111111", stall);
        end
        #2 resetn = 1'b0;
        #1;
        vec_cnt++;
        if ({stall, flush, new_pc, stall3, flush3} !== {6'd0, 1'b0, 32'd0, 6'd0, 1'b0}) begin
            err_cnt++; $display("FAIL rst_async: stall=%b flush=%b new_pc=%h want 0", stall, flush, new_pc);
        end
        drain_busy = 1'b0;
        step();
        #3 resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            vec_cnt++;
            if ({flush, flush3, stall} !== {1'b0, 1'b0, 6'd0}) begin
                err_cnt++; $display("FAIL rst_lost[%0d]: flush=%b flush3=%b stall=%b want 0", c, flush, flush3, stall);
            end
        end
    endtask

    task automatic test_wdog();
        stall_req = 6'b000100;
        repeat (4) step();
        vec_cnt++;
        if (wdog !== 1'b0) begin
            err_cnt++; $display("FAIL wdog_early: wdog=%b want 0", wdog);
        end
        repeat (6) step();
`ifdef PIPE_CTRL_WDOG_EN
        vec_cnt++;
        if (wdog !== 1'b1) begin
            err_cnt++; $display("FAIL wdog_set: wdog=%b want 1", wdog);
        end
        stall_req = 6'd0;
        repeat (3) step();
        vec_cnt++;
        if (wdog !== 1'b1) begin
            err_cnt++; $display("FAIL wdog_sticky: wdog=%b want 1", wdog);
        end
`else
        vec_cnt++;
        if ({wdog, wdog3} !== 2'b00) begin
            err_cnt++; $display("FAIL wdog_off: wdog=%b wdog3=%b want 0", wdog, wdog3);
        end
        stall_req = 6'd0;
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_stall_prio();
        test_excp_basic();
        test_drain();
        test_flush_len();
        test_reset_mid_drain();
        test_wdog();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
